// File: rtl/phy_rx_deserializer_if.sv
// Serial lane receive interface: serial bit stream in, aligned bytes out.
// The deserializer uses the slave modport; the lane source or bench uses master.
interface phy_rx_deserializer_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/phy_rx_deserializer.sv
// phy_rx_deserializer: receive end of one PHY serial lane.
// Shifts in one bit per clk_32f edge (MSB first), hunts for the COMMA byte to
// find byte alignment, needs BC_COUNT consecutive aligned commas to go ACTIVE,
// then delivers each aligned non-comma byte with a one-cycle valid strobe.
// Optional feature macro: PHY_RX_LOSS_OF_SYNC_EN -- when defined, four
// misaligned commas seen in ACTIVE (with no aligned comma between them)
// drop the lane back to SEARCH.
module phy_rx_deserializer #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    phy_rx_deserializer_if.slave  rx
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        SYNCING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_t     state_q,     state_d;
    logic [7:0] sr_q,        sr_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0] bc_cnt_q,    bc_cnt_d;
    logic [7:0] data_out_q,  data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       active_q,    active_d;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
    logic [2:0] misalign_cnt_q, misalign_cnt_d;
`endif

    logic [7:0] byte_w_s;
    logic [3:0] bc_inc_s;
    logic       boundary_s;
    logic       comma_s;

    // Next-state, alignment tracking and output computation
    always_comb begin
        byte_w_s    = {sr_q[6:0], rx.serial_in};
        bc_inc_s    = bc_cnt_q + 4'd1;
        boundary_s  = (bit_cnt_q == 3'd7);
        comma_s     = (byte_w_s == COMMA);

        state_d     = state_q;
        sr_d        = byte_w_s;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        bc_cnt_d    = bc_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        active_d    = active_q;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
        misalign_cnt_d = misalign_cnt_q;
`endif

        case (state_q)
            SEARCH: begin
                // bit_cnt is parked at 0 so the first aligned byte ends 8 cycles after the match
                bit_cnt_d = 3'd0;
                if (comma_s) begin
                    state_d  = SYNCING;
                    bc_cnt_d = 4'd1;
                end else begin
                    state_d  = SEARCH;
                end
            end
            SYNCING: begin
                if (boundary_s) begin
                    if (comma_s) begin
                        bc_cnt_d = bc_inc_s;
                        if (bc_inc_s == BC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            state_d  = SYNCING;
                        end
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = 4'd0;
                    end
                end else begin
                    state_d = SYNCING;
                end
            end
            ACTIVE: begin
                if (boundary_s) begin
                    data_out_d  = byte_w_s;
                    valid_out_d = !comma_s;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
                    if (comma_s) begin
                        misalign_cnt_d = 3'd0;
                    end else begin
                        misalign_cnt_d = misalign_cnt_q;
                    end
`endif
                end else begin
                    valid_out_d = 1'b0;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
                    if (comma_s) begin
                        if (misalign_cnt_q == 3'd3) begin
                            state_d        = SEARCH;
                            active_d       = 1'b0;
                            bc_cnt_d       = 4'd0;
                            misalign_cnt_d = 3'd0;
                        end else begin
                            misalign_cnt_d = misalign_cnt_q + 3'd1;
                        end
                    end else begin
                        misalign_cnt_d = misalign_cnt_q;
                    end
`endif
                end
            end
            default: begin
                state_d  = SEARCH;
                bc_cnt_d = 4'd0;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            bc_cnt_q    <= 4'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
            misalign_cnt_q <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            bc_cnt_q    <= bc_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
`ifdef PHY_RX_LOSS_OF_SYNC_EN
            misalign_cnt_q <= misalign_cnt_d;
`endif
        end
    end

    assign rx.data_out  = data_out_q;
    assign rx.valid_out = valid_out_q;
    assign rx.active    = active_q;

endmodule
